ram_entry_writer: RTL and testbench

- Operator-entry writer for the dual-port RAM: each debounced press of a board key writes the current switch value into the next RAM word.
- It is the write-side counterpart of the FSM/RAM/7-segment readback path, which reads the same RAM and shows its contents.
- Sits between the board keys/switches and RAM port A.
- Provides sequential addressing, wrap-around, an address clear, and a last-written echo for the hex displays.

---
 rtl/ram_entry_writer.sv | 195 +++++++++++++++++++
 tb/tb_ram_entry_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_entry_writer.sv
// ram_entry_writer: turns each debounced press of a board key into one RAM
// write on port A. The switch value is written at a sequential address that
// wraps. A second key clears the address, and the last written word is echoed.
module ram_entry_writer #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 16,
  parameter int SW_WIDTH        = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LAST_ADDR       = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_n,
  input  logic                  clr_n,
  input  logic [SW_WIDTH-1:0]   sw,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic                  busy
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0]  DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0]  DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A   = ADDR_WIDTH'(LAST_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]              key_sync_q;
  logic [1:0]              clr_sync_q;
  logic                    clr_prev_q;
  logic                    clr_pend_q, clr_pend_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   next_addr_q, next_addr_d;
  logic [DATA_WIDTH-1:0]   last_data_q, last_data_d;
  logic                    busy_q, busy_d;

  logic                    key_s;
  logic                    clr_s;
  logic                    clr_req_s;

  // Saturating increment of the shared debounce counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    if (c == DEB_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + CNT_WIDTH'(1);
    end
  endfunction

  // Sequential address step with wrap after LAST_ADDR.
  function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_A) begin
      addr_step = '0;
    end else begin
      addr_step = a + ADDR_WIDTH'(1);
    end
  endfunction

  assign key_s     = key_sync_q[1];
  assign clr_s     = clr_sync_q[1];
  // Clear is a synchronized low seen on two consecutive cycles.
  assign clr_req_s = ~clr_s & ~clr_prev_q;

  // Two-flop synchronizers for both keys; reset to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_q <= 2'b11;
      clr_sync_q <= 2'b11;
      clr_prev_q <= 1'b1;
    end else begin
      key_sync_q <= {key_sync_q[0], key_n};
      clr_sync_q <= {clr_sync_q[0], clr_n};
      clr_prev_q <= clr_s;
    end
  end

  // Next-state, debounce counter, write datapath and address-clear handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_pend_d  = clr_pend_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    next_addr_d = next_addr_q;
    last_data_d = last_data_q;
    case (state_q)
      ST_IDLE: begin
        if ((key_s == 1'b0) && (cnt_q == DEB_LAST)) begin
          // Accepted press: issue the write with the current address.
          state_d     = ST_WRITE;
          cnt_d       = '0;
          we_d        = 1'b1;
          addr_d      = next_addr_q;
          wdata_d     = DATA_WIDTH'(sw);
          last_data_d = DATA_WIDTH'(sw);
          next_addr_d = addr_step(next_addr_q);
          // A clear colliding with the write is applied one cycle later.
          if (clr_req_s) begin
            clr_pend_d = 1'b1;
          end else begin
            clr_pend_d = clr_pend_q;
          end
        end else begin
          if (key_s == 1'b0) begin
            cnt_d = sat_inc(cnt_q);
          end else begin
            cnt_d = '0;
          end
          if (clr_req_s || clr_pend_q) begin
            next_addr_d = '0;
            clr_pend_d  = 1'b0;
          end else begin
            clr_pend_d  = clr_pend_q;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
        if (clr_req_s) begin
          clr_pend_d = 1'b1;
        end else begin
          clr_pend_d = clr_pend_q;
        end
      end
      ST_RELEASE: begin
        if ((key_s == 1'b1) && (cnt_q == DEB_LAST)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (key_s == 1'b1) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          cnt_d = '0;
        end
        if (clr_req_s || clr_pend_q) begin
          next_addr_d = '0;
          clr_pend_d  = 1'b0;
        end else begin
          clr_pend_d  = clr_pend_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        clr_pend_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_pend_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      next_addr_q <= '0;
      last_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_pend_q  <= clr_pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      next_addr_q <= next_addr_d;
      last_data_q <= last_data_d;
      busy_q      <= busy_d;
    end
  end

  assign we        = we_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign next_addr = next_addr_q;
  assign last_data = last_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_entry_writer.sv
// Testbench for ram_entry_writer with short debounce (4) and wrap (3).
module tb_ram_entry_writer;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int SWW  = 10;
  localparam int DEB  = 4;
  localparam int LAST = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           key_n;
  logic           clr_n;
  logic [SWW-1:0] sw;
  logic           we;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [AW-1:0]  next_addr;
  logic [DW-1:0]  last_data;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Reference model: operator-level view (armed / writing / waiting release).
  int m_mode;     // 0 armed, 1 write cycle, 2 waiting for release
  int m_run;      // consecutive synchronized samples at the awaited level
  bit m_k1, m_k2, m_c1, m_c2, m_cprev, m_pend;
  bit m_we;
  int m_addr, m_wdata, m_next, m_last;

  // Per-phase observation
  int edge_no;
  int first_we;
  int we_cnt;
  int wr_addr_q[$];
  int wr_data_q[$];

  ram_entry_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SW_WIDTH(SWW),
    .DEBOUNCE_CYCLES(DEB), .LAST_ADDR(LAST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .clr_n(clr_n), .sw(sw),
    .we(we), .addr(addr), .wdata(wdata), .next_addr(next_addr),
    .last_data(last_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0;
    m_k1 = 1'b1; m_k2 = 1'b1; m_c1 = 1'b1; m_c2 = 1'b1; m_cprev = 1'b1;
    m_pend = 1'b0; m_we = 1'b0;
    m_addr = 0; m_wdata = 0; m_next = 0; m_last = 0;
  endtask

  // One rising edge of the reference behaviour, given inputs seen at that edge.
  task automatic model_edge(input bit k, input bit c, input int s);
    bit ks, clr_req;
    ks      = m_k2;
    clr_req = (m_c2 == 1'b0) && (m_cprev == 1'b0);
    m_cprev = m_c2;
    m_k2 = m_k1; m_k1 = k;
    m_c2 = m_c1; m_c1 = c;
    m_we = 1'b0;
    if (m_mode == 0) begin
      m_run = (ks == 1'b0) ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_we = 1'b1; m_addr = m_next; m_wdata = s; m_last = s;
        m_next = (m_next == LAST) ? 0 : m_next + 1;
        m_mode = 1; m_run = 0;
        if (clr_req) m_pend = 1'b1;
      end else if (clr_req || m_pend) begin
        m_next = 0; m_pend = 1'b0;
      end
    end else if (m_mode == 1) begin
      m_mode = 2; m_run = 0;
      if (clr_req) m_pend = 1'b1;
    end else begin
      m_run = (ks == 1'b1) ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_mode = 0; m_run = 0;
      end
      if (clr_req || m_pend) begin
        m_next = 0; m_pend = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_we"},        32'(we),        32'(m_we));
    chk({tag, "_addr"},      32'(addr),      32'(m_addr));
    chk({tag, "_wdata"},     32'(wdata),     32'(m_wdata));
    chk({tag, "_next_addr"}, 32'(next_addr), 32'(m_next));
    chk({tag, "_last_data"}, 32'(last_data), 32'(m_last));
    chk({tag, "_busy"},      32'(busy),      32'(m_mode != 0));
  endtask

  task automatic clear_obs();
    edge_no = 0; first_we = -1; we_cnt = 0;
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  // Called at a falling edge: drive, take one rising edge, check at next falling edge.
  task automatic step(input logic k, input logic c, input logic [SWW-1:0] s);
    key_n = k; clr_n = c; sw = s;
    @(posedge clk);
    model_edge(k, c, int'(s));
    @(negedge clk);
    edge_no++;
    check_outputs("cyc");
    if (we === 1'b1) begin
      we_cnt++;
      wr_addr_q.push_back(int'(addr));
      wr_data_q.push_back(int'(wdata));
      if (first_we < 0) first_wead_fix();
    end
  endtask

  task automatic first_wead_fix();
    first_we = edge_no;
  endtask

  // Called at a falling edge: asynchronous reset pulse spanning one rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [SWW-1:0] s);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, s);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, s);
  endtask

  initial begin
    logic kl;
    int   klen;
    int   clen;
    logic cv;

    rst_n = 1'b0; key_n = 1'b1; clr_n = 1'b1; sw = '0;
    model_reset();
    @(negedge clk);
    do_reset("reset");

    // Idle after reset: nothing happens
    clear_obs();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 10'h155);
    chk("idle_we_count", 32'(we_cnt), 32'd0);
    chk("idle_next_addr", 32'(next_addr), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single press with latency check
    clear_obs();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 10'h2A5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'h2A5);
    chk("single_we_count", 32'(we_cnt), 32'd1);
    chk("single_latency", 32'(first_we), 32'd6);
    chk("single_next_addr", 32'(next_addr), 32'd1);
    chk("single_last_data", 32'(last_data), 32'h02A5);
    chk("single_busy", 32'(busy), 32'd0);
    if (wr_addr_q.size() > 0) begin
      chk("single_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("single_wdata", 32'(wr_data_q[0]), 32'h02A5);
    end

    // Short glitches are rejected
    clear_obs();
    for (int p = 0; p < 5; p++) begin
      step(1'b0, 1'b1, 10'h3FF);
      step(1'b0, 1'b1, 10'h3FF);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'h3FF);
    end
    chk("glitch_we_count", 32'(we_cnt), 32'd0);
    chk("glitch_next_addr", 32'(next_addr), 32'd1);

    // Five presses with wrap-around
    do_reset("reset2");
    clear_obs();
    for (int i = 1; i <= 5; i++) press(SWW'(i));
    chk("wrap_we_count", 32'(we_cnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_q.size()) begin
        chk("wrap_addr", 32'(wr_addr_q[i]), 32'(i % 4));
        chk("wrap_wdata", 32'(wr_data_q[i]), 32'(i + 1));
      end
    end
    chk("wrap_next_addr", 32'(next_addr), 32'd1);

    // Address clear in IDLE
    do_reset("reset3");
    press(10'h011);
    press(10'h022);
    chk("clr_pre_next_addr", 32'(next_addr), 32'd2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'h000);
    chk("clr_next_addr", 32'(next_addr), 32'd0);
    chk("clr_last_data", 32'(last_data), 32'h0022);
    clear_obs();
    press(10'h033);
    chk("clr_we_count", 32'(we_cnt), 32'd1);
    if (wr_addr_q.size() > 0) chk("clr_write_addr", 32'(wr_addr_q[0]), 32'd0);

    // Reset during RELEASE with key still held
    clear_obs();
    for (int i = 0; i < 20 && we_cnt == 0; i++) step(1'b0, 1'b1, 10'h0AB);
    chk("rstrel_first_write", 32'(we_cnt), 32'd1);
    step(1'b0, 1'b1, 10'h0AB);
    step(1'b0, 1'b1, 10'h0AB);
    chk("rstrel_busy_before", 32'(busy), 32'd1);
    do_reset("rstrel");
    clear_obs();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 10'h0CD);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'h0CD);
    chk("rstrel_we_count", 32'(we_cnt), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("rstrel_addr", 32'(wr_addr_q[0]), 32'd0);
      chk("rstrel_wdata", 32'(wr_data_q[0]), 32'h00CD);
    end

    // Randomized key/clear activity against the model
    kl = 1'b1; klen = 0; clen = 0;
    for (int i = 0; i < 600; i++) begin
      if (klen == 0) begin
        kl   = ~kl;
        klen = $urandom_range(1, 9);
      end
      klen--;
      if (clen == 0 && $urandom_range(0, 15) == 0) clen = $urandom_range(1, 4);
      cv = (clen > 0) ? 1'b0 : 1'b1;
      if (clen > 0) clen--;
      step(kl, cv, SWW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
